// File: rtl/ctr_seq_pkg.sv
// +--------------------------------------------------------------+
// | ctr_seq_pkg : shared types and default widths for the CTR     |
// | block sequencer.                               rev 1.0        |
// +--------------------------------------------------------------+
`default_nettype none

package ctr_seq_pkg;

  localparam int C_BLOCK_W        = 128;
  localparam int C_CNT_W          = 64;
  localparam int C_LEN_W          = 16;
  localparam int C_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_KICK   = 3'd2,
    S_RUN    = 3'd3,
    S_OUT    = 3'd4,
    S_FINISH = 3'd5,
    S_ABORT  = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ctr_seq_timeout.sv
// +--------------------------------------------------------------+
// | ctr_seq_timeout : loadable up-counter with clear, enable and  |
// | terminal-count flag.                           rev 1.0        |
// +--------------------------------------------------------------+
`default_nettype none

module ctr_seq_timeout #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int COUNT_W        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic               i_load,
  input  logic [COUNT_W-1:0] i_load_val,
  output logic               o_tc
);

  localparam logic [COUNT_W-1:0] C_LAST = COUNT_W'(TIMEOUT_CYCLES - 1);

  logic [COUNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == C_LAST);

endmodule

`default_nettype wire

// File: rtl/ctr_block_sequencer.sv
// +--------------------------------------------------------------+
// | ctr_block_sequencer : streams plaintext blocks through the    |
// | Twofish CTR core, one reset/run cycle per block.  rev 1.0     |
// +--------------------------------------------------------------+
`default_nettype none

module ctr_block_sequencer
  import ctr_seq_pkg::*;
#(
  parameter int BLOCK_W        = C_BLOCK_W,
  parameter int CNT_W          = C_CNT_W,
  parameter int LEN_W          = C_LEN_W,
  parameter int TIMEOUT_CYCLES = C_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [BLOCK_W-1:0] i_iv,
  input  logic [BLOCK_W-1:0] i_key,
  input  logic [CNT_W-1:0]   i_first_block,
  input  logic [LEN_W-1:0]   i_n_blocks,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [BLOCK_W-1:0] i_in_data,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [BLOCK_W-1:0] o_out_data,
  output logic               o_out_last,
  output logic               o_core_rst,
  output logic [BLOCK_W-1:0] o_core_iv,
  output logic [BLOCK_W-1:0] o_core_key,
  output logic [BLOCK_W-1:0] o_core_text,
  output logic [CNT_W-1:0]   o_core_block_number,
  input  logic [BLOCK_W-1:0] i_core_text_o,
  input  logic               i_core_end,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_timeout_err,
  output logic [LEN_W-1:0]   o_blocks_done
);

  localparam int C_TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BLOCK_W-1:0] r_iv;
  logic [BLOCK_W-1:0] r_key;
  logic [BLOCK_W-1:0] r_text;
  logic [CNT_W-1:0]   r_block_num;
  logic [LEN_W-1:0]   r_n_blocks;
  logic [LEN_W-1:0]   r_blocks_done;
  logic [BLOCK_W-1:0] r_out_data;
  logic               r_out_last;
  logic               r_timeout_err;
  logic               r_zero_done;
  logic               w_tc;
  logic               w_cnt_clr;
  logic               w_cnt_en;

  ctr_seq_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .COUNT_W        (C_TO_W)
  ) u_timeout (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_cnt_clr),
    .i_en       (w_cnt_en),
    .i_load     (1'b0),
    .i_load_val ({C_TO_W{1'b0}}),
    .o_tc       (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_core_rst  = 1'b1;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        o_done = r_zero_done;
        if (i_start && (i_n_blocks != '0)) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        o_in_ready = 1'b1;
        if (i_in_valid) w_state_nxt = S_KICK;
      end
      S_KICK: begin
        w_cnt_clr   = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        o_core_rst = 1'b0;
        w_cnt_en   = 1'b1;
        // a finishing core takes priority over a timeout in the same cycle
        if (i_core_end)  w_state_nxt = S_OUT;
        else if (w_tc)   w_state_nxt = S_ABORT;
      end
      S_OUT: begin
        o_out_valid = 1'b1;
        if (i_out_ready) w_state_nxt = r_out_last ? S_FINISH : S_LOAD;
      end
      S_FINISH: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_ABORT: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iv          <= '0;
      r_key         <= '0;
      r_text        <= '0;
      r_block_num   <= '0;
      r_n_blocks    <= '0;
      r_blocks_done <= '0;
      r_out_data    <= '0;
      r_out_last    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_zero_done   <= 1'b0;
    end else begin
      r_zero_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_iv          <= i_iv;
            r_key         <= i_key;
            r_block_num   <= i_first_block;
            r_n_blocks    <= i_n_blocks;
            r_blocks_done <= '0;
            r_timeout_err <= 1'b0;
            r_zero_done   <= (i_n_blocks == '0);
          end
        end
        S_LOAD: begin
          if (i_in_valid) r_text <= i_in_data;
        end
        S_RUN: begin
          if (i_core_end) begin
            r_out_data <= i_core_text_o;
            r_out_last <= (r_blocks_done == (r_n_blocks - 1'b1));
          end else if (w_tc) begin
            r_timeout_err <= 1'b1;
          end
        end
        S_OUT: begin
          if (i_out_ready) begin
            r_blocks_done <= r_blocks_done + 1'b1;
            r_block_num   <= r_block_num + 1'b1;
          end
        end
        S_FINISH: r_out_last <= 1'b0;
        default: ;
      endcase
    end
  end

  assign o_out_data          = r_out_data;
  assign o_out_last          = r_out_last;
  assign o_core_iv           = r_iv;
  assign o_core_key          = r_key;
  assign o_core_text         = r_text;
  assign o_core_block_number = r_block_num;
  assign o_timeout_err       = r_timeout_err;
  assign o_blocks_done       = r_blocks_done;

endmodule

`default_nettype wire

// File: tb/tb_ctr_block_sequencer.sv
// +--------------------------------------------------------------+
// | tb_ctr_block_sequencer : randomized self-checking bench with  |
// | a behavioural CTR core model.                  rev 1.0        |
// +--------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_ctr_block_sequencer;

  localparam int BW = 128;
  localparam int CW = 64;
  localparam int LW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0, t_start = 1'b0;
  logic [BW-1:0] iv = '0, key = '0, in_data = '0;
  logic [CW-1:0] first_block = '0;
  logic [LW-1:0] n_blocks = '0;
  logic          in_valid = 1'b0, out_ready = 1'b0;

  logic          in_ready, out_valid, out_last, core_rst, busy, done, timeout_err, core_end;
  logic [BW-1:0] out_data, core_iv, core_key, core_text, core_text_o;
  logic [CW-1:0] core_bn;
  logic [LW-1:0] blocks_done;

  logic          t_in_ready, t_out_valid, t_out_last, t_core_rst, t_busy, t_done, t_timeout_err;
  logic [BW-1:0] t_out_data, t_core_iv, t_core_key, t_core_text;
  logic [CW-1:0] t_core_bn;
  logic [LW-1:0] t_blocks_done;

  int asserts = 0;
  int failures = 0;

  ctr_block_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_iv(iv), .i_key(key),
    .i_first_block(first_block), .i_n_blocks(n_blocks),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_out_last(out_last), .o_core_rst(core_rst), .o_core_iv(core_iv),
    .o_core_key(core_key), .o_core_text(core_text), .o_core_block_number(core_bn),
    .i_core_text_o(core_text_o), .i_core_end(core_end), .o_busy(busy),
    .o_done(done), .o_timeout_err(timeout_err), .o_blocks_done(blocks_done)
  );

  // Second instance with a short timeout and a core that never finishes
  ctr_block_sequencer #(.TIMEOUT_CYCLES(16)) u_dut_to (
    .clk(clk), .rst_n(rst_n), .i_start(t_start), .i_iv(iv), .i_key(key),
    .i_first_block(first_block), .i_n_blocks(n_blocks),
    .i_in_valid(in_valid), .o_in_ready(t_in_ready), .i_in_data(in_data),
    .o_out_valid(t_out_valid), .i_out_ready(1'b1), .o_out_data(t_out_data),
    .o_out_last(t_out_last), .o_core_rst(t_core_rst), .o_core_iv(t_core_iv),
    .o_core_key(t_core_key), .o_core_text(t_core_text), .o_core_block_number(t_core_bn),
    .i_core_text_o({BW{1'b0}}), .i_core_end(1'b0), .o_busy(t_busy),
    .o_done(t_done), .o_timeout_err(t_timeout_err), .o_blocks_done(t_blocks_done)
  );

  // Core model: result is a fixed mix of its operands, valid once it has run lat cycles
  function automatic logic [BW-1:0] cipher(input logic [BW-1:0] v, input logic [BW-1:0] k,
                                           input logic [BW-1:0] t, input logic [CW-1:0] b);
    return v ^ k ^ {t[63:0], t[127:64]} ^ {b, ~b};
  endfunction

  int lat = 20;
  int run_cnt = 0;
  always @(posedge clk) begin
    if (core_rst) run_cnt <= 0;
    else          run_cnt <= run_cnt + 1;
  end
  assign core_end    = !core_rst && (run_cnt >= lat);
  assign core_text_o = core_end ? cipher(core_iv, core_key, core_text, core_bn) : '0;

  // Monitor: done pulses and the block number presented at each core release
  logic          prev_crst = 1'b1;
  int            done_cnt = 0;
  logic [CW-1:0] bn_q[$];
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (prev_crst && !core_rst) bn_q.push_back(core_bn);
    prev_crst <= core_rst;
  end

  task automatic run_blocks(input logic [CW-1:0] first, input int n, input int lat_i,
                            input bit toggle, input bit spurious, input bit one_data,
                            input string tag);
    logic [BW-1:0] e_iv, e_key, text, held, exp;
    int d0;
    bit seen, ok;
    lat   = lat_i;
    e_iv  = {$urandom, $urandom, $urandom, $urandom};
    e_key = {$urandom, $urandom, $urandom, $urandom};
    bn_q.delete();
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; iv = e_iv; key = e_key; first_block = first; n_blocks = LW'(n);
    @(posedge clk); #1;
    start = 1'b0;
    if (spurious) begin
      start = 1'b1; first_block = ~first; n_blocks = LW'(n + 3); iv = '0; key = '0;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      text = one_data ? BW'(1) : {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'b1; in_data = text;
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (in_ready) begin ok = 1'b1; break; end
      end
      asserts++;
      if (!ok) begin
        failures++;
        $display("FAIL %s in_ready blk %0d: got 0, expected 1 within 100 cycles", tag, i);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = '0;
      exp  = cipher(e_iv, e_key, text, first + CW'(i));
      seen = 1'b0; ok = 1'b0; out_ready = 1'b0;
      for (int c = 0; c < 300; c++) begin
        out_ready = toggle ? ~out_ready : 1'b1;
        @(negedge clk);
        if (out_valid) begin
          if (!seen) begin
            held = out_data; seen = 1'b1;
          end else begin
            asserts++;
            if (out_data !== held) begin
              failures++;
              $display("FAIL %s stall_stable blk %0d: got %h, expected %h", tag, i, out_data, held);
            end
          end
          if (out_ready) begin
            asserts++;
            if (out_data !== exp) begin
              failures++;
              $display("FAIL %s out_data blk %0d: got %h, expected %h", tag, i, out_data, exp);
            end
            asserts++;
            if (out_last !== 1'(i == n - 1)) begin
              failures++;
              $display("FAIL %s out_last blk %0d: got %b, expected %b", tag, i, out_last, (i == n - 1));
            end
            ok = 1'b1;
            break;
          end
        end
        @(posedge clk); #1;
      end
      asserts++;
      if (!ok) begin
        failures++;
        $display("FAIL %s out_handshake blk %0d: got none, expected within 300 cycles", tag, i);
        out_ready = 1'b0;
        return;
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    asserts++;
    if (!ok) begin
      failures++;
      $display("FAIL %s done: got 0, expected pulse within 10 cycles", tag);
    end
    repeat (3) @(posedge clk);
    #1;
    asserts++;
    if (done_cnt - d0 !== 1) begin
      failures++;
      $display("FAIL %s done_count: got %0d, expected 1", tag, done_cnt - d0);
    end
    asserts++;
    if ({busy, out_last, blocks_done} !== {1'b0, 1'b0, LW'(n)}) begin
      failures++;
      $display("FAIL %s end_state busy/last/blocks_done: got %b/%b/%0d, expected 0/0/%0d",
               tag, busy, out_last, blocks_done, n);
    end
    asserts++;
    if (bn_q.size() !== n) begin
      failures++;
      $display("FAIL %s core_releases: got %0d, expected %0d", tag, bn_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        asserts++;
        if (bn_q[i] !== first + CW'(i)) begin
          failures++;
          $display("FAIL %s block_number %0d: got %h, expected %h", tag, i, bn_q[i], first + CW'(i));
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    asserts++;
    if ({in_ready, out_valid, out_last, core_rst, busy, done, timeout_err} !== 7'b0001000) begin
      failures++;
      $display("FAIL reset_flags: got %b, expected 0001000",
               {in_ready, out_valid, out_last, core_rst, busy, done, timeout_err});
    end
    asserts++;
    if ({out_data, core_iv, core_key, core_text, core_bn, blocks_done} !== '0) begin
      failures++;
      $display("FAIL reset_data: got nonzero out_data/core operands/blocks_done, expected 0");
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    asserts++;
    if ({busy, core_rst, in_ready, done} !== 4'b0100) begin
      failures++;
      $display("FAIL idle_after_reset busy/core_rst/in_ready/done: got %b, expected 0100",
               {busy, core_rst, in_ready, done});
    end
  endtask

  task automatic test_zero_blocks();
    bit bad;
    bad = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; n_blocks = '0; first_block = 64'd9;
    @(negedge clk);
    asserts++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL zero done_early: got %b, expected 0", done);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    asserts++;
    if ({done, busy} !== 2'b10) begin
      failures++;
      $display("FAIL zero done/busy: got %b, expected 10", {done, busy});
    end
    repeat (5) begin
      @(negedge clk);
      if (in_ready || !core_rst || done) bad = 1'b1;
    end
    asserts++;
    if (bad) begin
      failures++;
      $display("FAIL zero quiet: got in_ready/core release/extra done, expected none");
    end
  endtask

  task automatic test_timeout();
    int k;
    bit ok;
    @(posedge clk); #1;
    t_start = 1'b1; n_blocks = 16'd1; first_block = 64'd77;
    @(posedge clk); #1;
    t_start = 1'b0; in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom};
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (t_in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 20 && ok; c++) begin
      @(negedge clk);
      if (!t_core_rst) break;
    end
    asserts++;
    if (!ok || t_core_rst) begin
      failures++;
      $display("FAIL timeout run_entry: got core_rst=%b, expected 0", t_core_rst);
    end
    k = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (t_done) begin k = c; break; end
    end
    asserts++;
    if (k !== 16) begin
      failures++;
      $display("FAIL timeout abort_cycle: got %0d, expected 16", k);
    end
    asserts++;
    if ({t_timeout_err, t_core_rst, t_out_valid, t_blocks_done} !== {1'b1, 1'b1, 1'b0, 16'd0}) begin
      failures++;
      $display("FAIL timeout abort_state err/core_rst/out_valid/blocks_done: got %b/%b/%b/%0d, expected 1/1/0/0",
               t_timeout_err, t_core_rst, t_out_valid, t_blocks_done);
    end
    @(negedge clk);
    asserts++;
    if ({t_busy, t_done, t_timeout_err} !== 3'b001) begin
      failures++;
      $display("FAIL timeout sticky busy/done/err: got %b, expected 001", {t_busy, t_done, t_timeout_err});
    end
    @(posedge clk); #1;
    t_start = 1'b1; n_blocks = '0;
    @(posedge clk); #1;
    t_start = 1'b0;
    @(negedge clk);
    asserts++;
    if (t_timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout clear_on_start: got %b, expected 0", t_timeout_err);
    end
  endtask

  task automatic test_reset_mid_run();
    int d0;
    bit ok;
    lat = 25;
    @(posedge clk); #1;
    start = 1'b1; n_blocks = 16'd3; first_block = 64'd42;
    iv = {4{$urandom}}; key = {4{$urandom}};
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom};
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!core_rst) begin ok = 1'b1; break; end
      if (in_ready) begin @(posedge clk); #1; in_valid = 1'b0; end
    end
    in_valid = 1'b0;
    asserts++;
    if (!ok) begin
      failures++;
      $display("FAIL midreset run_entry: got core_rst=1, expected 0");
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    asserts++;
    if ({in_ready, out_valid, out_last, core_rst, busy, done, timeout_err} !== 7'b0001000) begin
      failures++;
      $display("FAIL midreset flags: got %b, expected 0001000",
               {in_ready, out_valid, out_last, core_rst, busy, done, timeout_err});
    end
    asserts++;
    if ({out_data, core_iv, core_key, core_text, core_bn, blocks_done} !== '0) begin
      failures++;
      $display("FAIL midreset data: got nonzero registers, expected 0");
    end
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    asserts++;
    if (done_cnt !== d0) begin
      failures++;
      $display("FAIL midreset no_done: got %0d pulses, expected 0", done_cnt - d0);
    end
    run_blocks(64'd100, 2, 6, 1'b0, 1'b1, 1'b0, "busy_start");
  endtask

  task automatic test_random();
    logic [CW-1:0] f;
    for (int r = 0; r < 5; r++) begin
      f = (r % 2 == 0) ? {$urandom, $urandom} : ~CW'($urandom_range(0, 3));
      run_blocks(f, $urandom_range(1, 5), $urandom_range(0, 30), 1'($urandom_range(0, 1)),
                 1'b0, 1'b0, "random");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    run_blocks(64'd5, 1, 20, 1'b0, 1'b0, 1'b1, "single");
    run_blocks(64'd5, 4, 9, 1'b1, 1'b0, 1'b0, "four_blocks");
    run_blocks(64'hFFFF_FFFF_FFFF_FFFF, 2, 7, 1'b0, 1'b0, 1'b0, "wrap");
    test_zero_blocks();
    test_timeout();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

`default_nettype wire
